mem_port_arbiter: RTL and testbench

Single-port memory arbiter for the multi-cycle RISC-V core. It shares one unified instruction/data memory port between the fetch stage (I port) and the load/store stage (D port). Each access is carried out as one registered transaction: grant, wait for memory ready, then a one-cycle acknowledge. It sits between the pipeline stages and the memory model in the CA_PROJECT top.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_streak_ctr.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned MAX_D_STREAK_DEF = 4;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} arb_state_e;
    typedef enum logic       {OWN_I, OWN_D}    owner_e;

endpackage

// File: rtl/arb_streak_ctr.sv
// Counts back-to-back D grants made while I waits; forces an I grant once the limit is hit.
module arb_streak_ctr #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_grant,
    input  logic i_grant_d,
    input  logic i_ireq,
    input  logic i_dreq,
    output logic o_force_i
);

    localparam int unsigned CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_grant) begin
            if (i_grant_d && i_ireq) begin
                w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
            end else begin
                w_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_force_i = (r_cnt == CNT_MAX) && i_ireq && i_dreq;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); D has priority.
// Optional starvation guard for I is enabled with MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    if (MAX_D_STREAK < 1) begin : g_bad_streak
        $error("MAX_D_STREAK must be at least 1");
    end

    arb_state_e          r_state;
    arb_state_e          w_state_next;
    owner_e              r_owner;
    logic                r_i_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W/8-1:0] r_mem_wstrb;

    logic w_grant;
    logic w_grant_d;
    logic w_force_i;
    logic w_done;

    assign w_grant   = (r_state == IDLE) && (i_req || d_req);
    assign w_grant_d = d_req && !w_force_i;
    assign w_done    = (r_state == BUSY) && mem_ready;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_streak_ctr #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk       (clk),
        .reset     (reset),
        .i_grant   (w_grant),
        .i_grant_d (w_grant_d),
        .i_ireq    (i_req),
        .i_dreq    (d_req),
        .o_force_i (w_force_i)
    );
`else
    assign w_force_i = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_req || d_req) w_state_next = BUSY;
            BUSY:    if (mem_ready) w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= OWN_I;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_i_ack <= w_done && (r_owner == OWN_I);
            r_d_ack <= w_done && (r_owner == OWN_D);
            if (w_grant) begin
                r_owner     <= w_grant_d ? OWN_D : OWN_I;
                r_mem_we    <= w_grant_d && d_we;
                r_mem_addr  <= w_grant_d ? d_addr : i_addr;
                r_mem_wdata <= w_grant_d ? d_wdata : '0;
                r_mem_wstrb <= w_grant_d ? d_wstrb : '0;
            end
            // Stores complete without touching the load data register.
            if (w_done) begin
                if (r_owner == OWN_I) begin
                    r_i_rdata <= mem_rdata;
                end else if (!r_mem_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_req   = (r_state == BUSY);
    assign busy      = (r_state != IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; grant-order expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [6:0] order;
        logic [6:0] exp_order;
        int         n_grants;
        int         d_done;

        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Reset state
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // Single load with two wait cycles
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h40;
        tick();
        check("ld_mem_req", mem_req, 1);
        check("ld_mem_addr", mem_addr, 32'h40);
        check("ld_mem_we", mem_we, 0);
        check("ld_busy", busy, 1);
        tick();
        check("ld_wait1", {mem_req, d_ack}, 2'b10);
        tick();
        check("ld_wait2", {mem_req, d_ack}, 2'b10);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("ld_d_ack", d_ack, 1);
        check("ld_i_ack", i_ack, 0);
        check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
        check("ld_mem_req_off", mem_req, 0);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        check("ld_ack_pulse", d_ack, 0);
        check("ld_idle", busy, 0);

        // Simultaneous I fetch and D store, zero-wait memory
        i_req     = 1'b1;
        i_addr    = 32'h100;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h200;
        d_wdata   = 32'h12345678;
        d_wstrb   = 4'hF;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE0001;
        tick();
        check("sim_d_first_addr", mem_addr, 32'h200);
        check("sim_d_we", mem_we, 1);
        check("sim_d_wdata", mem_wdata, 32'h12345678);
        check("sim_d_wstrb", mem_wstrb, 4'hF);
        tick();
        check("sim_d_ack", {i_ack, d_ack}, 2'b01);
        check("st_keeps_d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("sim_idle_gap", busy, 0);
        tick();
        check("sim_i_grant_addr", mem_addr, 32'h100);
        check("sim_i_we", mem_we, 0);
        check("sim_i_wstrb", mem_wstrb, 0);
        check("sim_i_wdata", mem_wdata, 0);
        tick();
        check("sim_i_ack", {i_ack, d_ack}, 2'b10);
        check("sim_i_rdata", i_rdata, 32'hCAFE0001);
        i_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // Request change while BUSY is ignored
        i_req  = 1'b1;
        i_addr = 32'h10;
        tick();
        check("chg_addr0", mem_addr, 32'h10);
        i_addr = 32'h20;
        tick();
        check("chg_addr1", mem_addr, 32'h10);
        mem_ready = 1'b1;
        mem_rdata = 32'h55;
        tick();
        check("chg_ack", i_ack, 1);
        check("chg_addr_at_ack", mem_addr, 32'h10);
        check("chg_i_rdata", i_rdata, 32'h55);
        i_req     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // mem_ready in IDLE has no effect
        mem_ready = 1'b1;
        mem_rdata = 32'h99;
        tick();
        check("idle_ready_busy", {busy, mem_req, i_ack, d_ack}, 0);
        check("idle_ready_rdata", {i_rdata, d_rdata}, {32'h55, 32'hDEADBEEF});
        mem_ready = 1'b0;

        // A load with I idle clears any streak before the arbitration run
        d_req  = 1'b1;
        d_addr = 32'h44;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h1234;
        tick();
        check("ld2_d_ack", d_ack, 1);
        d_req = 1'b0;
        tick();

        // Arbitration order with I waiting and six back-to-back D loads
        i_req     = 1'b1;
        i_addr    = 32'h100;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h300;
        mem_ready = 1'b1;
        order     = '0;
        n_grants  = 0;
        d_done    = 0;
        for (int cyc = 0; cyc < 60 && n_grants < 7; cyc++) begin
            tick();
            if (mem_req) begin
                order[n_grants] = (mem_addr != 32'h100);
                n_grants++;
            end
            if (d_ack) begin
                d_done++;
                if (d_done == 6) d_req = 1'b0;
                else d_addr = 32'h300 + 32'(4 * d_done);
            end
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_order = 7'b1101111;
`else
        exp_order = 7'b0111111;
`endif
        check("arb_grant_count", n_grants, 7);
        check("arb_grant_order", order, exp_order);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        tick();
        check("arb_drained", busy, 0);
        mem_ready = 1'b0;

        // Reset in the middle of a transaction
        d_req  = 1'b1;
        d_addr = 32'h80;
        tick();
        check("rmid_granted", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rmid_mem_req_async", mem_req, 0);
        check("rmid_busy_async", busy, 0);
        check("rmid_addr_async", mem_addr, 0);
        mem_ready = 1'b1;
        tick();
        check("rmid_no_ack", {i_ack, d_ack}, 0);
        check("rmid_d_rdata", d_rdata, 0);
        mem_ready = 1'b0;
        reset     = 1'b1;
        tick();
        check("rmid_regrant", {mem_req, mem_addr}, {1'b1, 32'h80});
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        tick();
        check("rmid_ack", d_ack, 1);
        check("rmid_rdata", d_rdata, 32'h77);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        check("rmid_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
